// File: rtl/ccg_sweep_pkg.sv
// Shared types and helpers for the exhaustive-sweep signature engine.
// Holds the FSM state enum, the default MISR taps and a width-generic MISR step.
package ccg_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SWEEP  = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_e;

    localparam int unsigned MISR_MAX_W = 32;
    localparam int unsigned MISR_IDX_W = $clog2(MISR_MAX_W);

    localparam logic [15:0] DEFAULT_SIG_POLY = 16'h002D;

    // One MISR shift on the low 'width' bits; poly and data must already fit in width.
    function automatic logic [MISR_MAX_W-1:0] misr_step(
        input logic [MISR_MAX_W-1:0] sig,
        input logic [MISR_MAX_W-1:0] poly,
        input logic [MISR_MAX_W-1:0] data,
        input int unsigned           width
    );
        logic [MISR_MAX_W-1:0] mask;
        logic [MISR_MAX_W-1:0] nxt;
        mask = {MISR_MAX_W{1'b1}} >> (MISR_MAX_W - width);
        nxt  = (sig << 1) ^ data;
        if (sig[MISR_IDX_W'(width - 1)]) begin
            nxt = nxt ^ poly;
        end
        return nxt & mask;
    endfunction

endpackage

// File: rtl/ccg_misr.sv
// Multiple-input signature register compacting one response word per enabled cycle.
// SIG_W must not exceed 32.
module ccg_misr
    import ccg_sweep_pkg::*;
#(
    parameter int unsigned      SIG_W     = 16,
    parameter logic [SIG_W-1:0] SIG_POLY  = SIG_W'(DEFAULT_SIG_POLY),
    parameter logic [SIG_W-1:0] SIG_SEED  = '0,
    parameter int unsigned      N_IN_DATA = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [N_IN_DATA-1:0] data,
    output logic [SIG_W-1:0]     sig
);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            sig <= SIG_SEED;
        end else if (enable) begin
            sig <= SIG_W'(misr_step(MISR_MAX_W'(sig), MISR_MAX_W'(SIG_POLY),
                                    MISR_MAX_W'(data), SIG_W));
        end
    end

endmodule

// File: rtl/ccg_sweep_sig.sv
// Exhaustive stimulus sweep of a combinational/pipelined DUT with MISR response compaction.
// Optional onset counter of dut_f[0] enabled by defining CCG_SWEEP_ONSET_EN.
module ccg_sweep_sig
    import ccg_sweep_pkg::*;
#(
    parameter int unsigned      N_IN        = 5,
    parameter int unsigned      N_OUT       = 8,
    parameter int unsigned      SIG_W       = 16,
    parameter logic [SIG_W-1:0] SIG_POLY    = SIG_W'(DEFAULT_SIG_POLY),
    parameter logic [SIG_W-1:0] SIG_SEED    = '0,
    parameter int unsigned      CAPTURE_LAT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [N_IN-1:0]  dut_x,
    input  logic [N_OUT-1:0] dut_f,
    output logic [N_IN-1:0]  vec_idx,
`ifdef CCG_SWEEP_ONSET_EN
    output logic [N_IN:0]    onset_cnt,
`endif
    output logic [SIG_W-1:0] signature
);

    localparam logic [N_IN-1:0] LAST_VEC   = '1;
    localparam logic [1:0]      DRAIN_LAST = (CAPTURE_LAT == 0) ? 2'd0 : 2'(CAPTURE_LAT - 1);

    state_e     state;
    state_e     state_nxt;
    logic       start_acc_c;
    logic       cap_v_c;
    logic [1:0] drain_cnt;

    assign start_acc_c = (state == IDLE) && start;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SWEEP;
                end
            end
            SWEEP: begin
                if (dut_x == LAST_VEC) begin
                    state_nxt = (CAPTURE_LAT == 0) ? FINISH : DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    state_nxt = FINISH;
                end
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status flags are registered copies of the upcoming state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nxt == SWEEP) || (state_nxt == DRAIN);
            done <= (state_nxt == FINISH);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dut_x <= '0;
        end else if (start_acc_c) begin
            dut_x <= '0;
        end else if ((state == SWEEP) && (dut_x != LAST_VEC)) begin
            dut_x <= dut_x + N_IN'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || (state != DRAIN)) begin
            drain_cnt <= 2'd0;
        end else begin
            drain_cnt <= drain_cnt + 2'd1;
        end
    end

    // Capture-valid tag and vector index follow the DUT pipeline depth.
    generate
        if (CAPTURE_LAT == 0) begin : g_no_lat
            assign cap_v_c = (state == SWEEP);
            assign vec_idx = dut_x;
        end else begin : g_lat
            logic [CAPTURE_LAT-1:0] vld_pipe;
            logic [N_IN-1:0]        idx_pipe [CAPTURE_LAT];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    vld_pipe <= '0;
                    for (int unsigned i = 0; i < CAPTURE_LAT; i++) begin
                        idx_pipe[i] <= '0;
                    end
                end else begin
                    vld_pipe[0] <= (state == SWEEP);
                    idx_pipe[0] <= dut_x;
                    for (int unsigned i = 1; i < CAPTURE_LAT; i++) begin
                        vld_pipe[i] <= vld_pipe[i-1];
                        idx_pipe[i] <= idx_pipe[i-1];
                    end
                end
            end

            assign cap_v_c = vld_pipe[CAPTURE_LAT-1];
            assign vec_idx = idx_pipe[CAPTURE_LAT-1];
        end
    endgenerate

    ccg_misr #(
        .SIG_W     (SIG_W),
        .SIG_POLY  (SIG_POLY),
        .SIG_SEED  (SIG_SEED),
        .N_IN_DATA (N_OUT)
    ) u_misr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (start_acc_c),
        .enable (cap_v_c),
        .data   (dut_f),
        .sig    (signature)
    );

`ifdef CCG_SWEEP_ONSET_EN
    localparam int unsigned CNT_W = N_IN + 1;

    always_ff @(posedge clk) begin
        if (!rst_n || start_acc_c) begin
            onset_cnt <= '0;
        end else if (cap_v_c && dut_f[0]) begin
            onset_cnt <= onset_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_ccg_sweep_sig.sv
// Self-checking bench for ccg_sweep_sig over several parameter sets and DUT functions.
// Expected signatures come from an arithmetic MISR model over a response table.
module tb_ccg_sweep_sig;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [4:0]  start_v;
    logic [4:0]  busy_v;
    logic [4:0]  done_v;
    logic [15:0] x_w   [5];
    logic [15:0] vi_w  [5];
    logic [15:0] sig_w [5];
    logic        sel0;
    logic        sel1;
    logic [7:0]  tbl2 [32];
    logic [3:0]  tbl4 [8];
    int          resp [32];
    int          total = 0;
    int          bad   = 0;

    // inst 0: 1-in / 1-out, f = x0 or ~x0
    logic [0:0] x0, vi0, f0;
    logic [3:0] s0;
`ifdef CCG_SWEEP_ONSET_EN
    logic [1:0] on0;
`endif
    ccg_sweep_sig #(.N_IN(1), .N_OUT(1), .SIG_W(4), .SIG_POLY(4'h3), .SIG_SEED(4'h0),
                    .CAPTURE_LAT(0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .dut_x(x0), .dut_f(f0), .vec_idx(vi0),
`ifdef CCG_SWEEP_ONSET_EN
        .onset_cnt(on0),
`endif
        .signature(s0));
    assign f0 = sel0 ? ~x0 : x0;

    // inst 1: 2-in / 1-out, f = x0&x1 or x0|x1
    logic [1:0] x1, vi1;
    logic [0:0] f1;
    logic [3:0] s1;
`ifdef CCG_SWEEP_ONSET_EN
    logic [2:0] on1;
`endif
    ccg_sweep_sig #(.N_IN(2), .N_OUT(1), .SIG_W(4), .SIG_POLY(4'h3), .SIG_SEED(4'h0),
                    .CAPTURE_LAT(0)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .dut_x(x1), .dut_f(f1), .vec_idx(vi1),
`ifdef CCG_SWEEP_ONSET_EN
        .onset_cnt(on1),
`endif
        .signature(s1));
    assign f1 = sel1 ? (x1[0] | x1[1]) : (x1[0] & x1[1]);

    // inst 2: default parameters, combinational table DUT
    logic [4:0]  x2, vi2;
    logic [7:0]  f2;
    logic [15:0] s2;
`ifdef CCG_SWEEP_ONSET_EN
    logic [5:0]  on2;
`endif
    ccg_sweep_sig u2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .dut_x(x2), .dut_f(f2), .vec_idx(vi2),
`ifdef CCG_SWEEP_ONSET_EN
        .onset_cnt(on2),
`endif
        .signature(s2));
    assign f2 = tbl2[x2];

    // inst 3: same table behind two register stages
    logic [4:0]  x3, vi3;
    logic [7:0]  f3, q3a, q3b;
    logic [15:0] s3;
`ifdef CCG_SWEEP_ONSET_EN
    logic [5:0]  on3;
`endif
    ccg_sweep_sig #(.CAPTURE_LAT(2)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start_v[3]), .busy(busy_v[3]), .done(done_v[3]),
        .dut_x(x3), .dut_f(f3), .vec_idx(vi3),
`ifdef CCG_SWEEP_ONSET_EN
        .onset_cnt(on3),
`endif
        .signature(s3));
    always_ff @(posedge clk) begin
        q3a <= tbl2[x3];
        q3b <= q3a;
    end
    assign f3 = q3b;

    // inst 4: nonzero seed, one register stage
    logic [2:0] x4, vi4;
    logic [3:0] f4, q4;
    logic [7:0] s4;
`ifdef CCG_SWEEP_ONSET_EN
    logic [3:0] on4;
`endif
    ccg_sweep_sig #(.N_IN(3), .N_OUT(4), .SIG_W(8), .SIG_POLY(8'h1D), .SIG_SEED(8'hA5),
                    .CAPTURE_LAT(1)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[4]), .busy(busy_v[4]), .done(done_v[4]),
        .dut_x(x4), .dut_f(f4), .vec_idx(vi4),
`ifdef CCG_SWEEP_ONSET_EN
        .onset_cnt(on4),
`endif
        .signature(s4));
    always_ff @(posedge clk) q4 <= tbl4[x4];
    assign f4 = q4;

    assign x_w[0] = 16'(x0);  assign vi_w[0] = 16'(vi0);  assign sig_w[0] = 16'(s0);
    assign x_w[1] = 16'(x1);  assign vi_w[1] = 16'(vi1);  assign sig_w[1] = 16'(s1);
    assign x_w[2] = 16'(x2);  assign vi_w[2] = 16'(vi2);  assign sig_w[2] = s2;
    assign x_w[3] = 16'(x3);  assign vi_w[3] = 16'(vi3);  assign sig_w[3] = s3;
    assign x_w[4] = 16'(x4);  assign vi_w[4] = 16'(vi4);  assign sig_w[4] = 16'(s4);

    // Signature of a w-bit MISR fed resp[0..n_vec-1] in order, plain arithmetic.
    function automatic int model_sig(input int w, input int poly, input int seed,
                                     input int n_vec, input int r [32]);
        int s;
        int modv;
        int top;
        s    = seed;
        modv = 1 << w;
        top  = 1 << (w - 1);
        for (int v = 0; v < n_vec; v++) begin
            s = ((s * 2) % modv) ^ ((s >= top) ? poly : 0) ^ r[v];
        end
        return s;
    endfunction

    function automatic int onset_model(input int n_vec, input int r [32]);
        int c;
        c = 0;
        for (int v = 0; v < n_vec; v++) c += r[v] % 2;
        return c;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int inst, input int limit);
        int cyc;
        cyc = 0;
        while (!done_v[inst] && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // Full sweep with timing, stimulus order and post-done quiet checks.
    task automatic run_sweep(input int inst, input bit retrig, input int n_in,
                             input int lat, input string tag);
        int busy_n, x_err, extra, cyc, n_vec;
        n_vec  = 1 << n_in;
        busy_n = 0;
        x_err  = 0;
        extra  = 0;
        cyc    = 0;
        @(negedge clk);
        start_v[inst] = 1'b1;
        @(negedge clk);
        start_v[inst] = retrig;
        while (!done_v[inst] && cyc < 300) begin
            if (busy_v[inst]) begin
                if (int'(x_w[inst]) != ((busy_n < n_vec) ? busy_n : n_vec - 1)) x_err++;
                busy_n++;
            end
            @(negedge clk);
            cyc++;
        end
        start_v[inst] = 1'b0;
        check({tag, "_done"}, 32'(done_v[inst]), 32'd1);
        check({tag, "_busy_at_done"}, 32'(busy_v[inst]), 32'd0);
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'(n_vec + lat));
        check({tag, "_x_seq"}, 32'(x_err), 32'd0);
        check({tag, "_vec_idx"}, 32'(vi_w[inst]), 32'(n_vec - 1));
        repeat (4) begin
            @(negedge clk);
            if (done_v[inst] || busy_v[inst]) extra++;
        end
        check({tag, "_quiet"}, 32'(extra), 32'd0);
    endtask

    int exp2;
    int exp4;
    int cnt;

    initial begin
        rst_n   = 1'b0;
        start_v = '0;
        sel0    = 1'b0;
        sel1    = 1'b0;
        for (int i = 0; i < 32; i++) tbl2[i] = 8'($urandom);
        for (int i = 0; i < 8; i++)  tbl4[i] = 4'($urandom);
        repeat (3) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            check($sformatf("rst_busy%0d", i), 32'(busy_v[i]), 32'd0);
            check($sformatf("rst_done%0d", i), 32'(done_v[i]), 32'd0);
            check($sformatf("rst_x%0d", i), 32'(x_w[i]), 32'd0);
            check($sformatf("rst_vi%0d", i), 32'(vi_w[i]), 32'd0);
            check($sformatf("rst_sig%0d", i), 32'(sig_w[i]), (i == 4) ? 32'hA5 : 32'h0);
        end
`ifdef CCG_SWEEP_ONSET_EN
        check("rst_onset2", 32'(on2), 32'd0);
`endif
        rst_n = 1'b1;

        // 1-input identity and inversion
        run_sweep(0, 1'b0, 1, 0, "a_x0");
        check("a_x0_sig", 32'(sig_w[0]), 32'h1);
`ifdef CCG_SWEEP_ONSET_EN
        check("a_x0_onset", 32'(on0), 32'd1);
`endif
        sel0 = 1'b1;
        run_sweep(0, 1'b0, 1, 0, "b_nx0");
        check("b_nx0_sig", 32'(sig_w[0]), 32'h2);
`ifdef CCG_SWEEP_ONSET_EN
        check("b_nx0_onset", 32'(on0), 32'd1);
`endif

        // 2-input AND / OR
        for (int f = 0; f < 2; f++) begin
            sel1 = f[0];
            for (int v = 0; v < 32; v++) begin
                resp[v] = (v >= 4) ? 0 : (f == 0) ? ((v & 1) & ((v >> 1) & 1))
                                                  : ((v & 1) | ((v >> 1) & 1));
            end
            run_sweep(1, 1'b0, 2, 0, (f == 0) ? "c_and" : "c_or");
            check((f == 0) ? "c_and_sig" : "c_or_sig", 32'(sig_w[1]),
                  32'(model_sig(4, 3, 0, 4, resp)));
`ifdef CCG_SWEEP_ONSET_EN
            check((f == 0) ? "c_and_onset" : "c_or_onset", 32'(on1), (f == 0) ? 32'd1 : 32'd3);
`endif
        end

        // random 5-in/8-out table: combinational, retriggered, and pipelined
        for (int v = 0; v < 32; v++) resp[v] = int'(tbl2[v]);
        exp2 = model_sig(16, 'h2D, 0, 32, resp);
        run_sweep(2, 1'b0, 5, 0, "d1");
        check("d1_sig", 32'(sig_w[2]), 32'(exp2));
`ifdef CCG_SWEEP_ONSET_EN
        check("d1_onset", 32'(on2), 32'(onset_model(32, resp)));
`endif
        run_sweep(2, 1'b1, 5, 0, "d2_retrig");
        check("d2_retrig_sig", 32'(sig_w[2]), 32'(exp2));
        run_sweep(3, 1'b0, 5, 2, "e_lat2");
        check("e_lat2_sig", 32'(sig_w[3]), 32'(exp2));
        check("e_lat2_vs_comb", 32'(sig_w[3]), 32'(sig_w[2]));

        // nonzero seed, latency 1
        for (int v = 0; v < 32; v++) resp[v] = (v < 8) ? int'(tbl4[v]) : 0;
        exp4 = model_sig(8, 'h1D, 'hA5, 8, resp);
        run_sweep(4, 1'b0, 3, 1, "f_seed");
        check("f_seed_sig", 32'(sig_w[4]), 32'(exp4));

        // start in the cycle right after done is accepted
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_done(0, 20);
        check("bb_done1", 32'(done_v[0]), 32'd1);
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        check("bb_busy2", 32'(busy_v[0]), 32'd1);
        wait_done(0, 20);
        check("bb_done2", 32'(done_v[0]), 32'd1);
        check("bb_sig2", 32'(sig_w[0]), 32'h2);

        // reset while vector 5 is on the bus aborts the sweep
        @(negedge clk);
        start_v[2] = 1'b1;
        @(negedge clk);
        start_v[2] = 1'b0;
        cnt = 0;
        while (x_w[2] != 16'd5 && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        check("mid_at_vec5", 32'(x_w[2]), 32'd5);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_busy", 32'(busy_v[2]), 32'd0);
        check("mid_x", 32'(x_w[2]), 32'd0);
        check("mid_sig", 32'(sig_w[2]), 32'd0);
        check("mid_done", 32'(done_v[2]), 32'd0);
        rst_n = 1'b1;
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_v[2] || busy_v[2]) cnt++;
        end
        check("mid_no_done", 32'(cnt), 32'd0);

        // fresh random table after the abort
        for (int i = 0; i < 32; i++) tbl2[i] = 8'($urandom);
        for (int v = 0; v < 32; v++) resp[v] = int'(tbl2[v]);
        exp2 = model_sig(16, 'h2D, 0, 32, resp);
        run_sweep(2, 1'b0, 5, 0, "g_comb");
        check("g_comb_sig", 32'(sig_w[2]), 32'(exp2));
        run_sweep(3, 1'b0, 5, 2, "g_lat2");
        check("g_lat2_sig", 32'(sig_w[3]), 32'(exp2));
        repeat (3) @(negedge clk);
        check("g_sig_hold", 32'(sig_w[2]), 32'(exp2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
